// File: rtl/hsv_pkg.sv
// Shared widths, frame geometry defaults and the pixel packing helper for the
// HSV pixel packer.
package hsv_pkg;

  localparam int DATA_W     = 32;
  localparam int PIX_W      = 3 * DATA_W;
  localparam int DEF_WIDTH  = 100;
  localparam int DEF_HEIGHT = 100;

  function automatic logic [PIX_W-1:0] pack_pixel(input logic [DATA_W-1:0] h,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [DATA_W-1:0] v);
    return {h, s, v};
  endfunction

endpackage

// File: rtl/hsv_pixel_packer_if.sv
// Component strobes from rgb2hsv and the packed-pixel valid/ready stream.
// The slave modport is the packer, the master modport is its surroundings.
interface hsv_pixel_packer_if #(
  parameter int DATA_W = hsv_pkg::DATA_W
) ();

  logic [DATA_W-1:0]   h;
  logic [DATA_W-1:0]   s;
  logic [DATA_W-1:0]   v;
  logic                h_valid;
  logic                s_valid;
  logic                v_valid;
  logic [3*DATA_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output h, s, v, h_valid, s_valid, v_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  h, s, v, h_valid, s_valid, v_valid, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/hsv_fifo.sv
// Show-ahead FIFO for packed pixels. A push into a full FIFO is only taken
// when a pop frees the head slot in the same cycle.
module hsv_fifo #(
  parameter  int PIX_W = 96,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             pop,
  output logic [PIX_W-1:0] head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero while empty so the output bus is clean out of reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hsv_pixel_packer.sv
// Collects independently strobed H, S and V results into one {h,s,v} word,
// buffers it, counts delivered pixels per frame and flags protocol errors.
module hsv_pixel_packer #(
  parameter  int DATA_W      = hsv_pkg::DATA_W,
  parameter  int DEPTH       = 8,
  parameter  int WIDTH       = hsv_pkg::DEF_WIDTH,
  parameter  int HEIGHT      = hsv_pkg::DEF_HEIGHT,
  localparam int TOTAL_PIXEL = WIDTH * HEIGHT,
  localparam int CNT_W       = $clog2(TOTAL_PIXEL),
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  hsv_pixel_packer_if.slave   bus,
  input  logic                clr_err,
  output logic [LVL_W-1:0]    level,
  output logic [CNT_W-1:0]    pix_cnt,
  output logic                frame_done,
  output logic                overflow,
  output logic                dup_err
);

  import hsv_pkg::*;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL_PIXEL - 1);

  logic [DATA_W-1:0] h_q, s_q, v_q;
  logic [DATA_W-1:0] h_sel, s_sel, v_sel;
  logic              got_h, got_s, got_v;
  logic              all_got;
  logic              dup_hit;
  logic              drop;
  logic              pop;
  logic              full;
  logic              empty;
  logic [PIX_W-1:0]  push_word;
  logic [PIX_W-1:0]  head;

  // Strobes arriving in the completing cycle bypass the capture registers.
  always_comb begin
    h_sel     = bus.h_valid ? bus.h : h_q;
    s_sel     = bus.s_valid ? bus.s : s_q;
    v_sel     = bus.v_valid ? bus.v : v_q;
    all_got   = (got_h | bus.h_valid) & (got_s | bus.s_valid) & (got_v | bus.v_valid);
    dup_hit   = ((got_h & bus.h_valid) | (got_s & bus.s_valid) | (got_v & bus.v_valid))
                & ~all_got;
    pop       = ~empty & bus.out_ready;
    drop      = all_got & full & ~pop;
    push_word = pack_pixel(h_sel, s_sel, v_sel);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q   <= '0;
      s_q   <= '0;
      v_q   <= '0;
      got_h <= 1'b0;
      got_s <= 1'b0;
      got_v <= 1'b0;
    end else begin
      if (bus.h_valid) h_q <= bus.h;
      if (bus.s_valid) s_q <= bus.s;
      if (bus.v_valid) v_q <= bus.v;
      got_h <= ~all_got & (got_h | bus.h_valid);
      got_s <= ~all_got & (got_s | bus.s_valid);
      got_v <= ~all_got & (got_v | bus.v_valid);
    end
  end

  hsv_fifo #(
    .PIX_W (PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (all_got),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  assign bus.out_data  = head;
  assign bus.out_valid = ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (pix_cnt == LAST_PIX) begin
          pix_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

  // A fresh error in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      dup_err  <= 1'b0;
    end else begin
      overflow <= drop    | (overflow & ~clr_err);
      dup_err  <= dup_hit | (dup_err  & ~clr_err);
    end
  end

endmodule

// File: tb/tb_hsv_pixel_packer.sv
// Directed plus randomized bench for hsv_pixel_packer, checked every cycle
// against a queue-based reference model of the packer.
module tb_hsv_pixel_packer;

  import hsv_pkg::*;

  localparam int DEPTH  = 8;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int TOTAL  = WIDTH * HEIGHT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] level;
  logic [2:0] pix_cnt;
  logic       frame_done;
  logic       overflow;
  logic       dup_err;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [PIX_W-1:0]  expQ[$];
  bit                pend[3];
  logic [DATA_W-1:0] pendVal[3];
  int                popsTotal;
  bit                expFrameDone;
  bit                expOverflow;
  bit                expDup;

  hsv_pixel_packer_if #(.DATA_W(DATA_W)) bus ();

  hsv_pixel_packer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_err    (clr_err),
    .level      (level),
    .pix_cnt    (pix_cnt),
    .frame_done (frame_done),
    .overflow   (overflow),
    .dup_err    (dup_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [PIX_W-1:0] obs,
                             input logic [PIX_W-1:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid",  PIX_W'(bus.out_valid), PIX_W'(expQ.size() != 0));
    checkOutput("level",      PIX_W'(level),         PIX_W'(expQ.size()));
    if (expQ.size() != 0) checkOutput("out_data", bus.out_data, expQ[0]);
    checkOutput("pix_cnt",    PIX_W'(pix_cnt),       PIX_W'(popsTotal % TOTAL));
    checkOutput("frame_done", PIX_W'(frame_done),    PIX_W'(expFrameDone));
    checkOutput("overflow",   PIX_W'(overflow),      PIX_W'(expOverflow));
    checkOutput("dup_err",    PIX_W'(dup_err),       PIX_W'(expDup));
  endtask

  task automatic modelReset();
    expQ.delete();
    pend         = '{0, 0, 0};
    pendVal      = '{'0, '0, '0};
    popsTotal    = 0;
    expFrameDone = 0;
    expOverflow  = 0;
    expDup       = 0;
  endtask

  task automatic driveIdle();
    bus.h_valid   = 1'b0;
    bus.s_valid   = 1'b0;
    bus.v_valid   = 1'b0;
    bus.h         = '0;
    bus.s         = '0;
    bus.v         = '0;
    bus.out_ready = 1'b0;
    clr_err       = 1'b0;
  endtask

  // Drives one cycle of inputs, advances the model, then checks after the edge.
  task automatic applyStimulus(input bit hv, input bit sv, input bit vv,
                               input logic [DATA_W-1:0] hd, input logic [DATA_W-1:0] sd,
                               input logic [DATA_W-1:0] vd, input bit rdy, input bit clr);
    bit                strobe[3];
    logic [DATA_W-1:0] d[3];
    logic [DATA_W-1:0] sel[3];
    bit                doPop, complete, dupNow, ovfNow;
    bus.h_valid = hv;  bus.s_valid = sv;  bus.v_valid = vv;
    bus.h = hd;  bus.s = sd;  bus.v = vd;
    bus.out_ready = rdy;
    clr_err = clr;
    strobe   = '{hv, sv, vv};
    d        = '{hd, sd, vd};
    doPop    = (expQ.size() != 0) && rdy;
    complete = 1;
    dupNow   = 0;
    ovfNow   = 0;
    for (int i = 0; i < 3; i++) begin
      if (!(pend[i] || strobe[i])) complete = 0;
      if (pend[i] && strobe[i]) dupNow = 1;
      sel[i] = strobe[i] ? d[i] : pendVal[i];
    end
    if (complete) dupNow = 0;
    expFrameDone = 0;
    if (doPop) begin
      expQ.delete(0);
      popsTotal++;
      expFrameDone = (popsTotal % TOTAL == 0);
    end
    if (complete) begin
      if (expQ.size() < DEPTH) expQ.push_back({sel[0], sel[1], sel[2]});
      else ovfNow = 1;
      pend = '{0, 0, 0};
    end else begin
      for (int i = 0; i < 3; i++)
        if (strobe[i]) begin
          pend[i]    = 1;
          pendVal[i] = d[i];
        end
    end
    expOverflow = ovfNow || (expOverflow && !clr);
    expDup      = dupNow || (expDup && !clr);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, '0, '0, rdy, 0);
  endtask

  task automatic doReset();
    driveIdle();
    rst = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int fdCount;
    logic [DATA_W-1:0] w;
    driveIdle();
    modelReset();
    #12;
    checkAll();
    checkOutput("reset_data", bus.out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // All three components in one cycle.
    applyStimulus(1, 1, 1, 32'h3F800000, 32'h3F000000, 32'h3F400000, 1, 0);
    checkOutput("t1_data", bus.out_data, 96'h3F800000_3F000000_3F400000);
    checkOutput("t1_level", PIX_W'(level), PIX_W'(1));
    idleCycles(1, 1);
    checkOutput("t1_pix_cnt", PIX_W'(pix_cnt), PIX_W'(1));

    // Components spread over eight cycles.
    applyStimulus(1, 0, 0, 32'h11111111, '0, '0, 0, 0);
    idleCycles(2, 0);
    applyStimulus(0, 1, 0, '0, 32'h22222222, '0, 0, 0);
    idleCycles(3, 0);
    checkOutput("t2_early_valid", PIX_W'(bus.out_valid), '0);
    applyStimulus(0, 0, 1, '0, '0, 32'h33333333, 0, 0);
    checkOutput("t2_data", bus.out_data, 96'h11111111_22222222_33333333);
    checkOutput("t2_dup", PIX_W'(dup_err), '0);
    idleCycles(1, 1);

    // Repeated hue strobe: newest value wins and the error is sticky until cleared.
    applyStimulus(1, 0, 0, 32'd1, '0, '0, 0, 0);
    idleCycles(1, 0);
    applyStimulus(1, 0, 0, 32'd2, '0, '0, 0, 0);
    checkOutput("t3_dup_set", PIX_W'(dup_err), PIX_W'(1));
    applyStimulus(0, 1, 1, '0, 32'd5, 32'd6, 0, 0);
    checkOutput("t3_data", bus.out_data, {32'd2, 32'd5, 32'd6});
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1);
    checkOutput("t3_dup_clr", PIX_W'(dup_err), '0);

    // Nine pixels into an eight-deep FIFO with the consumer stalled.
    for (int i = 1; i <= 9; i++) applyStimulus(1, 1, 1, i, i, i, 0, 0);
    checkOutput("t4_level", PIX_W'(level), PIX_W'(8));
    checkOutput("t4_overflow", PIX_W'(overflow), PIX_W'(1));
    for (int i = 1; i <= 8; i++) begin
      w = DATA_W'(i);
      checkOutput("t4_drain", bus.out_data, {w, w, w});
      idleCycles(1, 1);
    end
    checkOutput("t4_empty", PIX_W'(level), '0);

    // One full frame of eight pixels, then the first pixel of the next.
    doReset();
    fdCount = 0;
    for (int i = 0; i < TOTAL; i++) begin
      applyStimulus(1, 1, 1, $urandom, $urandom, $urandom, 1, 0);
      fdCount += int'(frame_done);
    end
    for (int i = 0; i < 3; i++) begin
      idleCycles(1, 1);
      fdCount += int'(frame_done);
    end
    checkOutput("t5_frame_pulses", PIX_W'(fdCount), PIX_W'(1));
    checkOutput("t5_wrap", PIX_W'(pix_cnt), '0);
    applyStimulus(1, 1, 1, $urandom, $urandom, $urandom, 1, 0);
    idleCycles(1, 1);
    checkOutput("t5_next_frame", PIX_W'(pix_cnt), PIX_W'(1));

    // Asynchronous reset with buffered pixels and a partial one pending.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, $urandom, $urandom, $urandom, 0, 0);
    applyStimulus(1, 0, 0, 32'hDEADBEEF, '0, '0, 0, 0);
    checkOutput("t6_level_before", PIX_W'(level), PIX_W'(3));
    #3;
    doReset();
    applyStimulus(0, 1, 0, '0, 32'hAAAA5555, '0, 1, 0);
    applyStimulus(0, 0, 1, '0, '0, 32'h5555AAAA, 1, 0);
    idleCycles(1, 1);
    checkOutput("t6_discarded", PIX_W'(bus.out_valid), '0);

    // Random traffic, alternating between free-flowing and mostly stalled consumer.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit busy;
      busy = ((cyc / 150) % 2) == 1;
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom,
                    busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hsv_pixel_packer.md
Name: hsv_pixel_packer

Overview:
Downstream stage of rgb2hsv. It captures the H, S and V results, which arrive on independent strobes at different cycles, and assembles them into one 96-bit pixel word {h,s,v}. The word is buffered in a small FIFO and delivered to the frame writer over a valid/ready handshake. The block also counts delivered pixels per frame and flags protocol errors.

Parameters:
DATA_W, 32, width of each component (IEEE-754 single word, treated as opaque bits)
DEPTH, 8, FIFO entries; power of two, >= 2
WIDTH, 100, frame width in pixels
HEIGHT, 100, frame height in pixels
TOTAL_PIXEL, WIDTH*HEIGHT, derived localparam; pixels per frame
CNT_W, $clog2(TOTAL_PIXEL), derived localparam; pixel counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
h  in  DATA_W  hue result
s  in  DATA_W  saturation result
v  in  DATA_W  value result
h_valid  in  1  h is valid this cycle (driven from valid_out_H)
s_valid  in  1  s is valid this cycle (driven from valid_out_S)
v_valid  in  1  v is valid this cycle (driven from valid_out_V)
clr_err  in  1  synchronous clear of the sticky error flags
out_data  out  3*DATA_W  FIFO head, packed as {h,s,v}
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_data
level  out  $clog2(DEPTH)+1  FIFO occupancy
pix_cnt  out  CNT_W  pixels popped in the current frame
frame_done  out  1  one-cycle pulse on the pop of the last pixel of a frame
overflow  out  1  sticky: a packed pixel was dropped because the FIFO was full
dup_err  out  1  sticky: a component strobe repeated before its pixel was packed

Behaviour:
- Reset: with rst low, every register and output is 0 immediately: capture regs, got_h/s/v flags, FIFO pointers, level, out_valid, out_data, pix_cnt, frame_done, overflow, dup_err. Reset mid-operation discards any partial pixel and all FIFO contents.
- Capture:
  - When x_valid is high, the capture reg x_q loads x and got_x is set.
  - If got_x is already 1 and the pixel does not complete in that cycle, dup_err is set and the newer value overwrites the older one.
- Completion:
  - all_got = (got_h|h_valid) & (got_s|s_valid) & (got_v|v_valid).
  - Same-cycle strobes are used directly by bypassing the capture regs.
  - On all_got, pack {h,s,v} as the push word and clear all three got flags in the same cycle.
- Push:
  - The push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set and the got flags still clear.
- FIFO:
  - Show-ahead: out_data is the head entry and out_valid = (level != 0).
  - Pop occurs when out_valid & out_ready.
  - Push into an empty FIFO becomes visible the next cycle; an empty FIFO never bypasses.
  - Latency: final strobe in cycle N gives out_valid high in cycle N+1.
  - Pointers wrap modulo DEPTH; level is updated +1, -1 or 0 (simultaneous push and pop).
  - out_data is held stable while out_valid & !out_ready.
- Frame counter:
  - pix_cnt increments on each pop.
  - On the pop where pix_cnt == TOTAL_PIXEL-1, pix_cnt wraps to 0 and frame_done is high for exactly the next cycle (registered).
  - Dropped pixels are not counted.
- Errors:
  - clr_err clears overflow and dup_err.
  - If a new error occurs in the same cycle as clr_err, the set wins.
- Unused: the upstream combined valid_out is not consumed.

Decomposition:
- Package hsv_pkg: DATA_W, PIX_W = 3*DATA_W, default WIDTH/HEIGHT, and a function packing h/s/v into a PIX_W word.
- One sub-module, hsv_fifo: synchronous show-ahead FIFO, parameterised by PIX_W and DEPTH, with ports push, push_data, pop, head, level, full, empty.
- hsv_pixel_packer contains the capture/alignment logic, the frame counter and the error flags.

Test Plan:
1. All three strobes together in cycle 0 with h=3F800000, s=3F000000, v=3F400000 and out_ready=1 -> cycle 1: out_valid=1, out_data=3F800000_3F000000_3F400000, level=1; cycle 2: level=0, pix_cnt=1.
2. h_valid in cycle 0, s_valid in cycle 3, v_valid in cycle 7 -> out_valid stays 0 through cycle 7 and rises in cycle 8 with the captured values; dup_err=0.
3. h_valid with h=1 in cycle 0 and again with h=2 in cycle 2, then s and v -> dup_err=1 from cycle 3; packed word has h=2; a clr_err pulse returns dup_err to 0.
4. DEPTH=8, out_ready=0, push 9 pixels with values 1..9 -> level=8, overflow=1, pixel 9 dropped; then out_ready=1 drains 1..8 in order and level returns to 0.
5. WIDTH=4, HEIGHT=2, stream 8 pixels with out_ready=1 -> frame_done high for exactly one cycle after the 8th pop; pix_cnt returns to 0 and the next frame counts from 1.
6. Assert rst=0 while level=3 and got_h=1 -> outputs clear asynchronously; after release, a fresh s and v alone produce no output (the partial pixel was discarded).
